// File: rtl/irrigation_ctrl.sv
// irrigation_ctrl: ADC sample sequencer, box-car averager and pump controller.
// Define PUMP_TIMEOUT_EN to enable the consecutive-on-window pump timeout.
module irrigation_ctrl #(
    parameter int RESOLUTION     = 10,
    parameter int AVG_LOG2       = 2,
    parameter int SAMPLE_PERIOD  = 1000,
    parameter int DRY_THRESH     = 700,
    parameter int WET_THRESH     = 400,
    parameter int RAIN_THRESH    = 300,
    parameter int MAX_ON_WINDOWS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [RESOLUTION-1:0] soil_digital,
    input  logic [RESOLUTION-1:0] dht11_digital,
    input  logic [RESOLUTION-1:0] rain_digital,
    output logic                  sensor_enable,
    output logic [RESOLUTION-1:0] soil_avg,
    output logic [RESOLUTION-1:0] dht11_avg,
    output logic [RESOLUTION-1:0] rain_avg,
    output logic                  avg_valid,
    output logic                  pump_on,
    output logic                  rain_lockout,
    output logic                  timeout_flag
);

    localparam int ACC_W  = RESOLUTION + AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam int WCNT_W = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [SCNT_W-1:0]     NSAMP = SCNT_W'(1 << AVG_LOG2);
    localparam logic [WCNT_W-1:0]     WLAST = WCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [RESOLUTION-1:0] DRY   = RESOLUTION'(DRY_THRESH);
    localparam logic [RESOLUTION-1:0] WET   = RESOLUTION'(WET_THRESH);
    localparam logic [RESOLUTION-1:0] RAIN  = RESOLUTION'(RAIN_THRESH);

    if (AVG_LOG2 < 0 || AVG_LOG2 > 6 || SAMPLE_PERIOD < 1 ||
        WET_THRESH >= DRY_THRESH || MAX_ON_WINDOWS < 1) begin : g_bad_cfg
        $error("irrigation_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_LAT,
        S_CAP,
        S_DECIDE
    } state_t;

    state_t                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [ACC_W-1:0]      acc_soil_q, acc_soil_d;
    logic [ACC_W-1:0]      acc_dht_q, acc_dht_d;
    logic [ACC_W-1:0]      acc_rain_q, acc_rain_d;
    logic [RESOLUTION-1:0] soil_avg_q, soil_avg_d;
    logic [RESOLUTION-1:0] dht_avg_q, dht_avg_d;
    logic [RESOLUTION-1:0] rain_avg_q, rain_avg_d;
    logic                  sen_q, sen_d;
    logic                  avalid_q, avalid_d;
    logic                  pump_q, pump_d;
    logic                  lock_q, lock_d;

    logic [ACC_W-1:0]      sum_soil, sum_dht, sum_rain;
    logic [RESOLUTION-1:0] soil_new, dht_new, rain_new;
    logic [SCNT_W-1:0]     scnt_inc;
    logic                  raining, pump_new;

    assign sum_soil = acc_soil_q + ACC_W'(soil_digital);
    assign sum_dht  = acc_dht_q + ACC_W'(dht11_digital);
    assign sum_rain = acc_rain_q + ACC_W'(rain_digital);
    assign soil_new = RESOLUTION'(sum_soil >> AVG_LOG2);
    assign dht_new  = RESOLUTION'(sum_dht >> AVG_LOG2);
    assign rain_new = RESOLUTION'(sum_rain >> AVG_LOG2);
    assign scnt_inc = scnt_q + 1'b1;

    // Rain lockout outranks soil; the band between thresholds holds the pump.
    always_comb begin
        raining  = (rain_new <= RAIN);
        pump_new = pump_q;
        if (raining) begin
            pump_new = 1'b0;
        end else if (soil_new >= DRY) begin
            pump_new = 1'b1;
        end else if (soil_new <= WET) begin
            pump_new = 1'b0;
        end
    end

`ifdef PUMP_TIMEOUT_EN
    localparam int ONW_W = $clog2(MAX_ON_WINDOWS + 1);
    localparam logic [ONW_W-1:0] ONW_MAX = ONW_W'(MAX_ON_WINDOWS);

    logic [ONW_W-1:0] onwin_q, onwin_d;
    logic [ONW_W-1:0] onwin_inc;
    logic             tout_q, tout_d;

    assign onwin_inc    = onwin_q + 1'b1;
    assign timeout_flag = tout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        scnt_d     = scnt_q;
        acc_soil_d = acc_soil_q;
        acc_dht_d  = acc_dht_q;
        acc_rain_d = acc_rain_q;
        soil_avg_d = soil_avg_q;
        dht_avg_d  = dht_avg_q;
        rain_avg_d = rain_avg_q;
        sen_d      = 1'b0;
        avalid_d   = 1'b0;
        pump_d     = pump_q;
        lock_d     = lock_q;
`ifdef PUMP_TIMEOUT_EN
        onwin_d    = onwin_q;
        tout_d     = tout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    if (wcnt_q == WLAST) begin
                        wcnt_d  = '0;
                        state_d = S_EN;
                        sen_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_EN: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                acc_soil_d = sum_soil;
                acc_dht_d  = sum_dht;
                acc_rain_d = sum_rain;
                scnt_d     = scnt_inc;
                if (scnt_inc == NSAMP) begin
                    // Results are registered so they are visible during DECIDE.
                    state_d    = S_DECIDE;
                    avalid_d   = 1'b1;
                    soil_avg_d = soil_new;
                    dht_avg_d  = dht_new;
                    rain_avg_d = rain_new;
                    lock_d     = raining;
`ifdef PUMP_TIMEOUT_EN
                    if (tout_q || !pump_new) begin
                        pump_d  = 1'b0;
                        onwin_d = '0;
                    end else if (onwin_inc == ONW_MAX) begin
                        pump_d  = 1'b0;
                        tout_d  = 1'b1;
                        onwin_d = '0;
                    end else begin
                        pump_d  = 1'b1;
                        onwin_d = onwin_inc;
                    end
`else
                    pump_d = pump_new;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECIDE: begin
                acc_soil_d = '0;
                acc_dht_d  = '0;
                acc_rain_d = '0;
                scnt_d     = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            scnt_q     <= '0;
            acc_soil_q <= '0;
            acc_dht_q  <= '0;
            acc_rain_q <= '0;
            soil_avg_q <= '0;
            dht_avg_q  <= '0;
            rain_avg_q <= '0;
            sen_q      <= 1'b0;
            avalid_q   <= 1'b0;
            pump_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            scnt_q     <= scnt_d;
            acc_soil_q <= acc_soil_d;
            acc_dht_q  <= acc_dht_d;
            acc_rain_q <= acc_rain_d;
            soil_avg_q <= soil_avg_d;
            dht_avg_q  <= dht_avg_d;
            rain_avg_q <= rain_avg_d;
            sen_q      <= sen_d;
            avalid_q   <= avalid_d;
            pump_q     <= pump_d;
            lock_q     <= lock_d;
        end
    end

`ifdef PUMP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            onwin_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            onwin_q <= onwin_d;
            tout_q  <= tout_d;
        end
    end
`endif

    assign sensor_enable = sen_q;
    assign avg_valid     = avalid_q;
    assign soil_avg      = soil_avg_q;
    assign dht11_avg     = dht_avg_q;
    assign rain_avg      = rain_avg_q;
    assign pump_on       = pump_q;
    assign rain_lockout  = lock_q;

endmodule
